// File: rtl/disp_pkg.sv
// Shared display-path definitions: frame-buffer scan states and the raster
// address helper used by both the frame-buffer writers and the scanout reader.
package disp_pkg;

  // Scan sequencing states for frame-buffer readers/writers.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } scan_state_e;

  // Raster address of pixel (x, y) in a buffer starting at base, w pixels per
  // line. Callers truncate the result to their own address width, so the
  // arithmetic wraps silently at that width.
  function automatic logic [31:0] fb_addr(input logic [31:0] base,
                                          input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic [15:0] w);
    return base + ({16'b0, y} * {16'b0, w}) + {16'b0, x};
  endfunction

endpackage

// File: rtl/arbiter_if.sv
// SDRAM arbiter port bundle. The client (master) drives the address/request
// side; the arbiter (slave) returns ack and in-order read data.
interface arbiter_if #(
  parameter int AN = 24,
  parameter int DN = 16
);
  logic [AN-1:0] addr;
  logic          req;
  logic          wr;
  logic [DN-1:0] data;
  logic          ack;
  logic          valid;
  logic [DN-1:0] mem;

  modport master (output addr, req, wr, data, input ack, valid, mem);
  modport slave  (input addr, req, wr, data, output ack, valid, mem);
endinterface

// File: rtl/disp_fifo.sv
// Synchronous pixel FIFO with flush. FD must be a power of two; pointers carry
// one extra wrap bit so count/full/empty fall out of a simple subtraction.
module disp_fifo #(
  parameter int DN = 16,
  parameter int FD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DN-1:0]        data_i,
  input  logic                 pop_i,
  output logic [DN-1:0]        data_o,
  output logic [$clog2(FD):0]  count_o,
  output logic                 empty_o,
  output logic                 full_o
);

  localparam int AW = $clog2(FD);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FD);

  logic [DN-1:0] mem_q [FD];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (count_o == FULL_CNT);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // Storage write.
  // NOTE: the data array is deliberately left out of reset; only the pointers
  // define validity, which lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  // Pointer next-state: flush empties the FIFO and overrides push/pop.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW + 1)'(1);
      if (do_pop)  rd_d = rd_q + (AW + 1)'(1);
    end
  end

  // Pointer registers.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/disp_scanout.sv
// Frame-buffer scanout: reads the displayed buffer from SDRAM through the
// arbiter read port and streams pixels in raster order to the TFT stage.
// Optional build macro DISP_SCANOUT_UNDERRUN_EN adds a saturating counter of
// cycles where the consumer was ready but no pixel was available.
// MODEL_TECH shrinks the default frame to 16x4 for simulation.
module disp_scanout
  import disp_pkg::*;
#(
  parameter int          AN   = 24,
  parameter int          DN   = 16,
  parameter int unsigned BASE = 0,
  parameter int unsigned SWAP = 384000,
`ifdef MODEL_TECH
  parameter int          W    = 16,
  parameter int          H    = 4,
`else
  parameter int          W    = 800,
  parameter int          H    = 480,
`endif
  parameter int          FD   = 16
) (
  input  logic          clkSYS,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          stat,
  output logic          busy,
  arbiter_if.master     sys,
  output logic [DN-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic [15:0]   underrun
);

  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = $clog2(FD) + 1;

  localparam logic [XW-1:0] X_LAST  = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(H - 1);
  localparam logic [CW:0]   RES_MAX = (CW + 1)'(FD);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_FETCH = S_FETCH;
  localparam logic [1:0] ST_DRAIN = S_DRAIN;

  logic [1:0]    state_q, state_d;
  logic [AN-1:0] base_q, base_d;
  logic [XW-1:0] x_q, x_d;          // request-side column
  logic [YW-1:0] y_q, y_d;          // request-side line
  logic [XW-1:0] ox_q, ox_d;        // output-side column
  logic [YW-1:0] oy_q, oy_d;        // output-side line
  logic [CW-1:0] inflight_q, inflight_d;
  logic          stale_q, stale_d;  // remaining in-flight reads belong to an aborted frame

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic [CW:0]   reserved;
  logic          ack_fire, ret_hit, push, pop, last_req;

  // Every acked read already owns a FIFO slot, so capping reserved at FD
  // guarantees the FIFO can never overflow.
  assign reserved = {1'b0, fifo_count} + {1'b0, inflight_q};

  // Request is withdrawn combinationally on frame_start so an abort cannot
  // be acked in the same cycle; new-frame requests wait for stale reads.
  assign sys.req  = (state_q == ST_FETCH) && !stale_q && !frame_start &&
                    (reserved < RES_MAX);
  assign sys.addr = AN'(fb_addr(32'(base_q), 16'(x_q), 16'(y_q), 16'(W)));
  assign sys.wr   = 1'b0;
  assign sys.data = '0;

  assign ack_fire = sys.req && sys.ack;
  assign ret_hit  = sys.valid && (inflight_q != '0);
  assign push     = ret_hit && !stale_q && !frame_start && !fifo_full;
  assign pop      = pix_valid && pix_ready;
  assign last_req = (x_q == X_LAST) && (y_q == Y_LAST);

  assign busy      = (state_q != ST_IDLE);
  assign pix_valid = !fifo_empty;
  assign pix_sof   = pix_valid && (ox_q == '0) && (oy_q == '0);
  assign pix_eol   = pix_valid && (ox_q == X_LAST);

  disp_fifo #(.DN(DN), .FD(FD)) u_fifo (
    .clk     (clkSYS),
    .rst     (reset),
    .flush_i (frame_start),
    .push_i  (push),
    .data_i  (sys.mem),
    .pop_i   (pop),
    .data_o  (pix_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Scan sequencing, request/response bookkeeping and raster counters.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    x_d        = x_q;
    y_d        = y_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;

    // Ack and return in the same cycle cancel out.
    case ({ack_fire, ret_hit})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (frame_start) begin
      state_d = ST_FETCH;
      base_d  = AN'(BASE) + (stat ? AN'(SWAP) : '0);
      x_d     = '0;
      y_d     = '0;
      ox_d    = '0;
      oy_d    = '0;
      stale_d = (inflight_d != '0);
    end else begin
      if (stale_q && (inflight_d == '0)) stale_d = 1'b0;

      if (ack_fire) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
        if (last_req) state_d = ST_DRAIN;
      end

      if (pop) begin
        if (ox_q == X_LAST) begin
          ox_d = '0;
          oy_d = (oy_q == Y_LAST) ? '0 : oy_q + YW'(1);
        end else begin
          ox_d = ox_q + XW'(1);
        end
      end

      if ((state_q == ST_DRAIN) && fifo_empty && (inflight_q == '0))
        state_d = ST_IDLE;
    end
  end

  // Control state registers.
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      inflight_q <= '0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end

`ifdef DISP_SCANOUT_UNDERRUN_EN
  logic [15:0] underrun_q, underrun_d;

  // Count starved cycles during a frame; saturate, restart per frame.
  always_comb begin
    underrun_d = underrun_q;
    if (frame_start)
      underrun_d = '0;
    else if (busy && pix_ready && !pix_valid && (underrun_q != 16'hFFFF))
      underrun_d = underrun_q + 16'd1;
  end

  // Underrun counter register.
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) underrun_q <= '0;
    else       underrun_q <= underrun_d;
  end

  assign underrun = underrun_q;
`else
  assign underrun = '0;
`endif

endmodule

// File: tb/tb_disp_scanout.sv
// Bench for disp_scanout at W=16, H=4, FD=8, BASE=0, SWAP=64 with a simple
// arbiter responder returning mem = addr a configurable number of cycles
// after each ack.
module tb_disp_scanout;

  localparam int NPIX = 64;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } pix_t;

  typedef struct {
    logic stat;
    int   mode;   // 0: always ready, 1: every other cycle, 2: one in three
    int   base;
  } fvec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic stat = 1'b0;
  logic busy;
  logic [15:0] pix_data;
  logic pix_valid;
  logic pix_ready = 1'b0;
  logic pix_sof, pix_eol;
  logic [15:0] underrun;

  int errors = 0;
  int checks = 0;

  logic        ack_en = 1'b1;
  int          lat = 2;
  logic        pv [8];
  logic [15:0] pa [8];
  int          ack_total = 0;
  int          valid_total = 0;
  pix_t        q[$];

  arbiter_if #(.AN(16), .DN(16)) sys_if ();

  disp_scanout #(
    .AN(16), .DN(16), .BASE(0), .SWAP(64), .W(16), .H(4), .FD(8)
  ) dut (
    .clkSYS      (clk),
    .reset       (rst),
    .frame_start (frame_start),
    .stat        (stat),
    .busy        (busy),
    .sys         (sys_if),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Responder: ack whatever is requested while enabled, return mem = addr.
  assign sys_if.ack   = sys_if.req & ack_en;
  assign sys_if.valid = pv[lat-1];
  assign sys_if.mem   = pa[lat-1];

  initial begin
    foreach (pv[i]) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
  end

  always @(posedge clk) begin
    pv[0] <= sys_if.req & sys_if.ack;
    pa[0] <= sys_if.addr;
    for (int i = 1; i < 8; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    if (sys_if.req && sys_if.ack) ack_total <= ack_total + 1;
    if (sys_if.valid) valid_total <= valid_total + 1;
  end

  // Pixel monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && pix_valid && pix_ready) q.push_back({pix_data, pix_sof, pix_eol});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pulse frame_start; verify the first request appears on the next cycle.
  task automatic start_frame(input logic s, input int base, input string name);
    @(posedge clk); #1;
    frame_start = 1'b1;
    stat = s;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    check($sformatf("%s_busy", name), busy, 1);
    check($sformatf("%s_first_req", name), sys_if.req, 1);
    check($sformatf("%s_first_addr", name), sys_if.addr, base);
  endtask

  task automatic wait_frame_end(input int mode, input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      pix_ready = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : ((c % 3) == 0);
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check($sformatf("%s_completed", name), done, 1);
  endtask

  task automatic check_frame(input int base, input string name);
    int nd, ns, ne;
    nd = 0; ns = 0; ne = 0;
    check($sformatf("%s_pixel_count", name), q.size(), NPIX);
    foreach (q[i]) begin
      if (q[i].data !== 16'(base + i)) nd++;
      if (q[i].sof !== (i == 0)) ns++;
      if (q[i].eol !== ((i % 16) == 15)) ne++;
    end
    check($sformatf("%s_bad_data", name), nd, 0);
    check($sformatf("%s_bad_sof", name), ns, 0);
    check($sformatf("%s_bad_eol", name), ne, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check($sformatf("%s_busy", name), busy, 0);
    check($sformatf("%s_req", name), sys_if.req, 0);
    check($sformatf("%s_addr", name), sys_if.addr, 0);
    check($sformatf("%s_pix_valid", name), pix_valid, 0);
    check($sformatf("%s_sof", name), pix_sof, 0);
    check($sformatf("%s_eol", name), pix_eol, 0);
    check($sformatf("%s_underrun", name), underrun, 0);
  endtask

  initial begin
    fvec_t fv [4];
    int a0, v0, nstab;
    logic found;

    fv[0] = '{stat: 1'b0, mode: 0, base: 0};
    fv[1] = '{stat: 1'b1, mode: 0, base: 64};
    fv[2] = '{stat: 1'b0, mode: 1, base: 0};
    fv[3] = '{stat: 1'b1, mode: 2, base: 64};

    // Reset state.
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Whole frames from either buffer under several consumer patterns.
    for (int i = 0; i < 4; i++) begin
      q.delete();
      pix_ready = 1'b1;
      start_frame(fv[i].stat, fv[i].base, $sformatf("frame%0d", i));
      wait_frame_end(fv[i].mode, $sformatf("frame%0d", i));
      check_frame(fv[i].base, $sformatf("frame%0d", i));
    end

    // Back-pressure: consumer stalls, fetch stops at FIFO depth.
    q.delete();
    pix_ready = 1'b0;
    a0 = ack_total;
    start_frame(1'b0, 0, "stall");
    repeat (50) @(negedge clk);
    check("stall_acks", ack_total - a0, 8);
    check("stall_req_low", sys_if.req, 0);
    check("stall_pix_valid", pix_valid, 1);
    check("stall_head_sof", pix_sof, 1);
    check("stall_no_pops", q.size(), 0);
    wait_frame_end(0, "stall");
    check_frame(0, "stall");

    // Abort with 3 reads in flight and 5 pixels buffered.
    lat = 4;
    q.delete();
    pix_ready = 1'b0;
    a0 = ack_total;
    v0 = valid_total;
    start_frame(1'b1, 64, "abort_old");
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (valid_total - v0 == 5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_setup_reached", found, 1);
    check("abort_setup_acks", ack_total - a0, 8);
    check("abort_setup_pix_valid", pix_valid, 1);
    frame_start = 1'b1;
    stat = 1'b0;
    #1;
    check("abort_req_withdrawn", sys_if.req, 0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    check("abort_flushed", pix_valid, 0);
    check("abort_busy", busy, 1);
    q.delete();
    pix_ready = 1'b1;
    wait_frame_end(0, "abort_new");
    check_frame(0, "abort_new");
    lat = 2;

    // Arbiter withholds ack: request and address must hold steady.
    q.delete();
    pix_ready = 1'b1;
    ack_en = 1'b0;
    start_frame(1'b1, 64, "ackhold");
    nstab = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (sys_if.req !== 1'b1 || sys_if.addr !== 16'd64) nstab++;
    end
    check("ackhold_req_addr_unstable", nstab, 0);
`ifdef DISP_SCANOUT_UNDERRUN_EN
    check("ackhold_underrun", underrun, 10);
`else
    check("ackhold_underrun", underrun, 0);
`endif
    ack_en = 1'b1;
    wait_frame_end(0, "ackhold");
    check_frame(64, "ackhold");

    // Asynchronous reset in the middle of a frame.
    q.delete();
    pix_ready = 1'b1;
    start_frame(1'b1, 64, "midreset");
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    check("midreset_held_busy", busy, 0);
    rst = 1'b0;
    q.delete();
    start_frame(1'b0, 0, "postreset");
    wait_frame_end(0, "postreset");
    check_frame(0, "postreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
